incr_arb: RTL and testbench

INCR_ARB -- requirements
Module: incr_arb

---
 rtl/incr_arb_pkg.sv | 14 +
 rtl/incr_arb_if.sv | 29 ++
 rtl/incr_arb_incr_unit.sv | 15 +
 rtl/incr_arb.sv | 118 +++++++++++
 tb/tb_incr_arb.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/incr_arb_pkg.sv
// incr_arb shared definitions: channel/width defaults and FSM encoding.
// Imported by the interface, the incrementer and the arbiter top.
package incr_arb_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 4;
   localparam int IDXW      = 2;

   typedef enum logic {
      IDLE = 1'b0,
      UPD  = 1'b1
   } state_t;

endpackage

// File: rtl/incr_arb_if.sv
// incr_arb channel bus: en/req/clr from the requesters,
// ack/wrap strobes, packed counts, grant index and busy back.
interface incr_arb_if
   import incr_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) ();

   logic                    en;
   logic [NREQ-1:0]         req;
   logic [NREQ-1:0]         clr;
   logic [NREQ-1:0]         ack;
   logic [NREQ-1:0]         wrap;
   logic [NREQ*WIDTH-1:0]   cnt_all;
   logic [IDXW-1:0]         gnt_idx;
   logic                    busy;

   modport master (
      output en, req, clr,
      input  ack, wrap, cnt_all, gnt_idx, busy
   );

   modport slave (
      input  en, req, clr,
      output ack, wrap, cnt_all, gnt_idx, busy
   );

endinterface

// File: rtl/incr_arb_incr_unit.sv
// incr_unit: the single shared WIDTH-bit +1 adder.
// a_i count in, y_o count+1 mod 2^WIDTH, co_o carry (wrap).
module incr_unit
   import incr_arb_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH-1:0] y_o,
   output logic             co_o
);

   assign {co_o, y_o} = {1'b0, a_i} + (WIDTH+1)'(1);

endmodule

// File: rtl/incr_arb.sv
// incr_arb: round-robin arbiter sharing one incrementer among
// NREQ counters. Ports: pulse (clock), rst_n (sync low), bus (slave).
module incr_arb
   import incr_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEF,
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic     pulse,
   input  logic     rst_n,
   incr_arb_if.slave bus
);

   state_t            state_q, state_d;
   logic [IDXW-1:0]   ptr_q, ptr_d;
   logic [IDXW-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [NREQ-1:0]   wrap_q, wrap_d;
   logic [WIDTH-1:0]  cnt_q [NREQ];
   logic [WIDTH-1:0]  cnt_d [NREQ];
   logic [NREQ-1:0]   elig;
   logic [WIDTH-1:0]  inc_y;
   logic              inc_co;

   // First eligible channel at or after ptr, ascending modulo NREQ.
   function automatic logic [IDXW-1:0] rr_pick(
      input logic [NREQ-1:0] el,
      input logic [IDXW-1:0] ptr
   );
      logic [IDXW-1:0] idx;
      logic            found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = IDXW'((int'(ptr) + k) % NREQ);
         if (!found && el[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   incr_unit #(.WIDTH(WIDTH)) u_inc (
      .a_i  (cnt_q[gnt_q]),
      .y_o  (inc_y),
      .co_o (inc_co)
   );

   // A channel acked this cycle still shows req; masking it
   // prevents a second count before the requester can drop.
   assign elig = bus.req & ~ack_q;

   always_ff @(posedge pulse) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         wrap_q  <= '0;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         wrap_q  <= wrap_d;
         for (int i = 0; i < NREQ; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.en && |elig) begin
               gnt_d   = rr_pick(elig, ptr_q);
               state_d = UPD;
            end
         end
         UPD: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Update datapath; clr overrides the increment and its wrap.
   always_comb begin
      ack_d  = '0;
      wrap_d = '0;
      ptr_d  = ptr_q;
      for (int i = 0; i < NREQ; i++) cnt_d[i] = cnt_q[i];
      if (state_q == UPD) begin
         cnt_d[gnt_q]  = inc_y;
         ack_d[gnt_q]  = 1'b1;
         wrap_d[gnt_q] = inc_co;
         ptr_d         = IDXW'((int'(gnt_q) + 1) % NREQ);
      end
      for (int i = 0; i < NREQ; i++) begin
         if (bus.clr[i]) begin
            cnt_d[i]  = '0;
            wrap_d[i] = 1'b0;
         end
      end
   end

   always_comb begin
      bus.cnt_all = '0;
      for (int i = 0; i < NREQ; i++) begin
         bus.cnt_all[i*WIDTH +: WIDTH] = cnt_q[i];
      end
   end

   assign bus.ack     = ack_q;
   assign bus.wrap    = wrap_q;
   assign bus.gnt_idx = gnt_q;
   assign bus.busy    = (state_q == UPD);

endmodule

// File: tb/tb_incr_arb.sv
// Directed bench for incr_arb: cycle table plus hand sequences
// for counter wrap and reset during an update.
module tb_incr_arb;

   logic pulse;
   logic rst_n;
   int   checks;
   int   errors;

   incr_arb_if #(.NREQ(4), .WIDTH(4)) bus ();

   incr_arb #(.NREQ(4), .WIDTH(4)) dut (
      .pulse (pulse),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial pulse = 1'b0;
   always #5 pulse = ~pulse;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [3:0]  req;
      logic [3:0]  clr;
      logic [3:0]  ack;
      logic [3:0]  wrap;
      logic        busy;
      logic [1:0]  gnt;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl [32];

   function automatic vec_t mk(
      input logic r, input logic e,
      input logic [3:0] q, input logic [3:0] c,
      input logic [3:0] a, input logic [3:0] w,
      input logic b, input logic [1:0] g,
      input logic [15:0] n
   );
      vec_t v;
      v.rst_n = r; v.en = e; v.req = q; v.clr = c;
      v.ack = a; v.wrap = w; v.busy = b; v.gnt = g; v.cnt = n;
      return v;
   endfunction

   task automatic step(
      input logic r, input logic e,
      input logic [3:0] q, input logic [3:0] c
   );
      rst_n   = r;
      bus.en  = e;
      bus.req = q;
      bus.clr = c;
      @(posedge pulse);
      #1;
   endtask

   task automatic chk(
      input string nm,
      input logic [3:0] a, input logic [3:0] w,
      input logic b, input logic [1:0] g,
      input logic [15:0] n
   );
      logic [26:0] got, want;
      got  = {bus.ack, bus.wrap, bus.busy, bus.gnt_idx, bus.cnt_all};
      want = {a, w, b, g, n};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s ack/wrap/busy/gnt/cnt got %h %h %b %0d %h want %h %h %b %0d %h",
                  nm, bus.ack, bus.wrap, bus.busy, bus.gnt_idx, bus.cnt_all,
                  a, w, b, g, n);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      bus.en  = 1'b0;
      bus.req = '0;
      bus.clr = '0;

      //              rst en req    clr     ack     wrap    bsy gnt cnt
      tbl[0]  = mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000);
      tbl[1]  = mk(1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000);
      tbl[2]  = mk(1, 1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h0001);
      tbl[3]  = mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0001);
      tbl[4]  = mk(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h0000);
      tbl[5]  = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h0000);
      tbl[6]  = mk(1, 1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h0001);
      tbl[7]  = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h0001);
      tbl[8]  = mk(1, 1, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 0, 1, 16'h0011);
      tbl[9]  = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 2, 16'h0011);
      tbl[10] = mk(1, 1, 4'b1111, 4'b0000, 4'b0100, 4'b0000, 0, 2, 16'h0111);
      tbl[11] = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 3, 16'h0111);
      tbl[12] = mk(1, 1, 4'b1111, 4'b0000, 4'b1000, 4'b0000, 0, 3, 16'h1111);
      tbl[13] = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 0, 16'h1111);
      tbl[14] = mk(1, 1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0, 16'h1112);
      tbl[15] = mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h1112);
      tbl[16] = mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 0, 16'h1112);
      tbl[17] = mk(1, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1112);
      tbl[18] = mk(1, 0, 4'b1111, 4'b0000, 4'b0010, 4'b0000, 0, 1, 16'h1122);
      tbl[19] = mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h1122);
      tbl[20] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1122);
      tbl[21] = mk(1, 1, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 0, 1, 16'h1130);
      tbl[22] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h1130);
      tbl[23] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1130);
      tbl[24] = mk(1, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1, 16'h1140);
      tbl[25] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h1140);
      tbl[26] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1140);
      tbl[27] = mk(1, 1, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 0, 1, 16'h1150);
      tbl[28] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h1150);
      tbl[29] = mk(1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1, 16'h1150);
      tbl[30] = mk(1, 1, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 1, 16'h1100);
      tbl[31] = mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 16'h1100);

      for (int i = 0; i < 32; i++) begin
         step(tbl[i].rst_n, tbl[i].en, tbl[i].req, tbl[i].clr);
         chk($sformatf("row%0d", i), tbl[i].ack, tbl[i].wrap,
             tbl[i].busy, tbl[i].gnt, tbl[i].cnt);
      end

      // Channel 2 up to 15, then one more increment wraps to 0.
      step(0, 0, 4'b0000, 4'b0000);
      chk("wrap_reset", 4'b0000, 4'b0000, 0, 0, 16'h0000);
      for (int k = 0; k < 15; k++) begin
         step(1, 1, 4'b0100, 4'b0000);
         step(1, 1, 4'b0100, 4'b0000);
         step(1, 1, 4'b0000, 4'b0000);
      end
      chk("cnt2_15", 4'b0000, 4'b0000, 0, 2, 16'h0F00);
      step(1, 1, 4'b0100, 4'b0000);
      chk("wrap_grant", 4'b0000, 4'b0000, 1, 2, 16'h0F00);
      step(1, 1, 4'b0100, 4'b0000);
      chk("wrap_strobe", 4'b0100, 4'b0100, 0, 2, 16'h0000);
      step(1, 1, 4'b0000, 4'b0000);
      chk("wrap_clear", 4'b0000, 4'b0000, 0, 2, 16'h0000);

      // Channel 3 to 7, move ptr to 2, then reset mid-update.
      step(0, 0, 4'b0000, 4'b0000);
      chk("rupd_reset", 4'b0000, 4'b0000, 0, 0, 16'h0000);
      for (int k = 0; k < 7; k++) begin
         step(1, 1, 4'b1000, 4'b0000);
         step(1, 1, 4'b1000, 4'b0000);
         step(1, 1, 4'b0000, 4'b0000);
      end
      chk("cnt3_7", 4'b0000, 4'b0000, 0, 3, 16'h7000);
      step(1, 1, 4'b0010, 4'b0000);
      step(1, 1, 4'b0010, 4'b0000);
      step(1, 1, 4'b0000, 4'b0000);
      chk("ch1_once", 4'b0000, 4'b0000, 0, 1, 16'h7010);
      step(1, 1, 4'b1000, 4'b0000);
      chk("rupd_grant3", 4'b0000, 4'b0000, 1, 3, 16'h7010);
      step(0, 1, 4'b1000, 4'b0000);
      chk("rupd_discard", 4'b0000, 4'b0000, 0, 0, 16'h0000);
      step(1, 1, 4'b1111, 4'b0000);
      chk("rupd_ptr0", 4'b0000, 4'b0000, 1, 0, 16'h0000);
      step(1, 1, 4'b1111, 4'b0000);
      chk("rupd_ack0", 4'b0001, 4'b0000, 0, 0, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
